// File: rtl/i2c_master_xfer_seq.sv
// i2c_master_xfer_seq: runs a complete register-style I2C write or read
// transfer from one request by sequencing byte-controller commands.
module i2c_master_xfer_seq #(
  parameter int unsigned MAX_LEN = 4,
  parameter int unsigned LW      = 3
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 req,
  input  logic                 rnw,
  input  logic [6:0]           dev_addr,
  input  logic [7:0]           reg_addr,
  input  logic [LW-1:0]        len,
  input  logic [8*MAX_LEN-1:0] wdata,
  output logic                 busy,
  output logic                 xfer_done,
  output logic                 err_nack,
  output logic                 err_al,
  output logic [8*MAX_LEN-1:0] rdata,
  output logic                 bc_start,
  output logic                 bc_stop,
  output logic                 bc_read,
  output logic                 bc_write,
  output logic                 bc_ack_in,
  output logic [7:0]           bc_din,
  input  logic                 bc_done,
  input  logic                 bc_ack_out,
  input  logic [7:0]           bc_dout,
  input  logic                 bc_al
);

  typedef enum logic [2:0] {IDLE, ADDR_W, REG, WDATA, ADDR_R, RDATA, ABORT_P, FIN} state_t;

  state_t               state, state_nxt;
  logic                 issued, issued_nxt;
  logic [LW-1:0]        k, k_nxt, len_q, len_nxt, len_clamped;
  logic                 rnw_q, rnw_nxt;
  logic [6:0]           dev_q, dev_nxt;
  logic [7:0]           reg_q, reg_nxt;
  logic [8*MAX_LEN-1:0] wdata_q, wdata_nxt, rdata_nxt;
  logic                 busy_nxt, done_nxt, nack_nxt, al_nxt;
  logic                 start_nxt, stop_nxt, read_nxt, write_nxt, ack_in_nxt;
  logic [7:0]           din_nxt;
  logic                 last;

  assign last = (k == len_q - LW'(1));

  always_comb begin
    len_clamped = len;
    if (len > LW'(MAX_LEN))
      len_clamped = LW'(MAX_LEN);
    else if (rnw && len == '0)
      len_clamped = LW'(1);
  end

  // issued=0 marks the all-zero gap cycle; the next edge loads the byte's commands
  always_comb begin
    state_nxt  = state;
    issued_nxt = issued;
    k_nxt      = k;
    len_nxt    = len_q;
    rnw_nxt    = rnw_q;
    dev_nxt    = dev_q;
    reg_nxt    = reg_q;
    wdata_nxt  = wdata_q;
    rdata_nxt  = rdata;
    busy_nxt   = busy;
    nack_nxt   = err_nack;
    al_nxt     = err_al;
    start_nxt  = bc_start;
    stop_nxt   = bc_stop;
    read_nxt   = bc_read;
    write_nxt  = bc_write;
    ack_in_nxt = bc_ack_in;
    din_nxt    = bc_din;
    case (state)
      IDLE: begin
        if (req) begin
          rnw_nxt    = rnw;
          dev_nxt    = dev_addr;
          reg_nxt    = reg_addr;
          wdata_nxt  = wdata;
          len_nxt    = len_clamped;
          busy_nxt   = 1'b1;
          nack_nxt   = 1'b0;
          al_nxt     = 1'b0;
          issued_nxt = 1'b0;
          state_nxt  = ADDR_W;
        end
      end
      FIN: begin
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end
      default: begin
        if (bc_al) begin
          {start_nxt, stop_nxt, read_nxt, write_nxt, ack_in_nxt} = '0;
          din_nxt    = '0;
          issued_nxt = 1'b0;
          al_nxt     = 1'b1;
          state_nxt  = FIN;
        end else if (!issued) begin
          issued_nxt = 1'b1;
          case (state)
            ADDR_W: begin
              start_nxt = 1'b1;
              write_nxt = 1'b1;
              din_nxt   = {dev_q, 1'b0};
            end
            REG: begin
              write_nxt = 1'b1;
              din_nxt   = reg_q;
              stop_nxt  = !rnw_q && (len_q == '0);
            end
            WDATA: begin
              write_nxt = 1'b1;
              din_nxt   = wdata_q[8*k +: 8];
              stop_nxt  = last;
            end
            ADDR_R: begin
              start_nxt = 1'b1;
              write_nxt = 1'b1;
              din_nxt   = {dev_q, 1'b1};
            end
            RDATA: begin
              read_nxt   = 1'b1;
              ack_in_nxt = last;
              stop_nxt   = last;
            end
            ABORT_P: stop_nxt = 1'b1;
            default: ;
          endcase
        end else if (bc_done) begin
          {start_nxt, stop_nxt, read_nxt, write_nxt, ack_in_nxt} = '0;
          din_nxt    = '0;
          issued_nxt = 1'b0;
          if (bc_ack_out && (state == ADDR_W || state == REG ||
                             state == ADDR_R || state == WDATA)) begin
            nack_nxt  = 1'b1;
            state_nxt = bc_stop ? FIN : ABORT_P;
          end else begin
            case (state)
              ADDR_W: state_nxt = REG;
              REG: begin
                k_nxt = '0;
                if (rnw_q)              state_nxt = ADDR_R;
                else if (len_q != '0)   state_nxt = WDATA;
                else                    state_nxt = FIN;
              end
              WDATA: begin
                k_nxt = k + LW'(1);
                if (last) state_nxt = FIN;
              end
              ADDR_R: begin
                k_nxt     = '0;
                state_nxt = RDATA;
              end
              RDATA: begin
                rdata_nxt[8*k +: 8] = bc_dout;
                k_nxt = k + LW'(1);
                if (last) state_nxt = FIN;
              end
              ABORT_P: state_nxt = FIN;
              default: ;
            endcase
          end
        end
      end
    endcase
    done_nxt = (state_nxt == FIN);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      issued    <= 1'b0;
      k         <= '0;
      len_q     <= '0;
      rnw_q     <= 1'b0;
      dev_q     <= '0;
      reg_q     <= '0;
      wdata_q   <= '0;
      rdata     <= '0;
      busy      <= 1'b0;
      xfer_done <= 1'b0;
      err_nack  <= 1'b0;
      err_al    <= 1'b0;
      bc_start  <= 1'b0;
      bc_stop   <= 1'b0;
      bc_read   <= 1'b0;
      bc_write  <= 1'b0;
      bc_ack_in <= 1'b0;
      bc_din    <= '0;
    end else begin
      state     <= state_nxt;
      issued    <= issued_nxt;
      k         <= k_nxt;
      len_q     <= len_nxt;
      rnw_q     <= rnw_nxt;
      dev_q     <= dev_nxt;
      reg_q     <= reg_nxt;
      wdata_q   <= wdata_nxt;
      rdata     <= rdata_nxt;
      busy      <= busy_nxt;
      xfer_done <= done_nxt;
      err_nack  <= nack_nxt;
      err_al    <= al_nxt;
      bc_start  <= start_nxt;
      bc_stop   <= stop_nxt;
      bc_read   <= read_nxt;
      bc_write  <= write_nxt;
      bc_ack_in <= ack_in_nxt;
      bc_din    <= din_nxt;
    end
  end

endmodule

// File: tb/tb_i2c_master_xfer_seq.sv
// Directed bench for i2c_master_xfer_seq: the bench plays the byte controller
// and checks every command set, flag and read-data value.
module tb_i2c_master_xfer_seq;

  localparam int unsigned MAX_LEN = 4;
  localparam int unsigned LW      = 3;

  // command vector bit order: {start, stop, read, write, ack_in}
  localparam logic [4:0] CS = 5'b10000, CP = 5'b01000, CR = 5'b00100,
                         CW = 5'b00010, CA = 5'b00001;

  logic                 clk = 1'b0;
  logic                 rstn = 1'b0;
  logic                 req = 1'b0, rnw = 1'b0;
  logic [6:0]           dev_addr = '0;
  logic [7:0]           reg_addr = '0;
  logic [LW-1:0]        len = '0;
  logic [8*MAX_LEN-1:0] wdata = '0;
  logic                 busy, xfer_done, err_nack, err_al;
  logic [8*MAX_LEN-1:0] rdata;
  logic                 bc_start, bc_stop, bc_read, bc_write, bc_ack_in;
  logic [7:0]           bc_din;
  logic                 bc_done = 1'b0, bc_ack_out = 1'b0, bc_al = 1'b0;
  logic [7:0]           bc_dout = '0;
  logic [4:0]           cmd;

  int unsigned vectors = 0, miscompares = 0;

  i2c_master_xfer_seq #(.MAX_LEN(MAX_LEN), .LW(LW)) dut (
    .clk(clk), .rstn(rstn), .req(req), .rnw(rnw), .dev_addr(dev_addr),
    .reg_addr(reg_addr), .len(len), .wdata(wdata), .busy(busy),
    .xfer_done(xfer_done), .err_nack(err_nack), .err_al(err_al), .rdata(rdata),
    .bc_start(bc_start), .bc_stop(bc_stop), .bc_read(bc_read), .bc_write(bc_write),
    .bc_ack_in(bc_ack_in), .bc_din(bc_din), .bc_done(bc_done),
    .bc_ack_out(bc_ack_out), .bc_dout(bc_dout), .bc_al(bc_al)
  );

  assign cmd = {bc_start, bc_stop, bc_read, bc_write, bc_ack_in};

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of run, expected finish before 200us");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_cmd(input string tag);
    int unsigned n = 0;
    while (cmd == '0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " issue"}, 32'(cmd != '0), 32'd1);
  endtask

  task automatic byte_op(input string tag, input logic [4:0] exp_cmd, input logic [7:0] exp_din,
                         input logic nack, input logic [7:0] dout);
    wait_cmd(tag);
    chk({tag, " cmd"}, 32'(cmd), 32'(exp_cmd));
    if (exp_cmd[1]) chk({tag, " din"}, 32'(bc_din), 32'(exp_din));
    @(negedge clk);
    chk({tag, " hold"}, 32'(cmd), 32'(exp_cmd));
    bc_ack_out = nack;
    bc_dout    = dout;
    bc_done    = 1'b1;
    @(negedge clk);
    bc_done    = 1'b0;
    bc_ack_out = 1'b0;
    bc_dout    = '0;
    chk({tag, " drop"}, 32'(cmd), 32'd0);
  endtask

  task automatic start_xfer(input logic r, input logic [6:0] dev, input logic [7:0] ra,
                            input logic [LW-1:0] l, input logic [31:0] wd);
    rnw = r; dev_addr = dev; reg_addr = ra; len = l; wdata = wd; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    chk("busy set", 32'(busy), 32'd1);
  endtask

  task automatic end_chk(input string tag, input logic exp_nack, input logic exp_al);
    chk({tag, " xfer_done"}, 32'(xfer_done), 32'd1);
    chk({tag, " err_nack"}, 32'(err_nack), 32'(exp_nack));
    chk({tag, " err_al"}, 32'(err_al), 32'(exp_al));
    @(negedge clk);
    chk({tag, " done pulse"}, 32'(xfer_done), 32'd0);
    chk({tag, " idle busy"}, 32'(busy), 32'd0);
    chk({tag, " idle cmd"}, 32'(cmd), 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst flags", 32'({xfer_done, err_nack, err_al}), 32'd0);
    chk("rst rdata", rdata, 32'd0);
    chk("rst cmd", 32'(cmd), 32'd0);
    chk("rst din", 32'(bc_din), 32'd0);
    rstn = 1'b1;
    @(negedge clk);

    // write len=2
    start_xfer(1'b0, 7'h50, 8'h10, 3'd2, 32'h0000BBAA);
    byte_op("wr dev", CS | CW, 8'hA0, 1'b0, 8'h00);
    byte_op("wr reg", CW, 8'h10, 1'b0, 8'h00);
    byte_op("wr d0", CW, 8'hAA, 1'b0, 8'h00);
    byte_op("wr d1", CP | CW, 8'hBB, 1'b0, 8'h00);
    end_chk("wr", 1'b0, 1'b0);

    // read len=3, req held high with different fields while busy
    start_xfer(1'b1, 7'h50, 8'h20, 3'd3, 32'h0);
    req = 1'b1; rnw = 1'b0; dev_addr = 7'h7F; reg_addr = 8'h55; len = 3'd1;
    byte_op("rd dev", CS | CW, 8'hA0, 1'b0, 8'h00);
    byte_op("rd reg", CW, 8'h20, 1'b0, 8'h00);
    byte_op("rd devr", CS | CW, 8'hA1, 1'b0, 8'h00);
    byte_op("rd b0", CR, 8'h00, 1'b0, 8'h11);
    byte_op("rd b1", CR, 8'h00, 1'b0, 8'h22);
    req = 1'b0;
    byte_op("rd b2", CR | CP | CA, 8'h00, 1'b0, 8'h33);
    chk("rd rdata", rdata, 32'h00332211);
    end_chk("rd", 1'b0, 1'b0);

    // NACK on device address byte
    start_xfer(1'b0, 7'h50, 8'h30, 3'd1, 32'h77);
    byte_op("nk dev", CS | CW, 8'hA0, 1'b1, 8'h00);
    byte_op("nk abort", CP, 8'h00, 1'b0, 8'h00);
    chk("nk rdata", rdata, 32'h00332211);
    end_chk("nk", 1'b1, 1'b0);

    // arbitration lost during REG
    start_xfer(1'b0, 7'h21, 8'h44, 3'd1, 32'h0);
    byte_op("al dev", CS | CW, 8'h42, 1'b0, 8'h00);
    wait_cmd("al reg");
    chk("al reg cmd", 32'(cmd), 32'(CW));
    chk("al reg din", 32'(bc_din), 32'h44);
    bc_al = 1'b1;
    @(negedge clk);
    bc_al = 1'b0;
    chk("al drop", 32'(cmd), 32'd0);
    end_chk("al", 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("al no stop", 32'(cmd), 32'd0);
    end

    // write len=0: stop rides on the register byte
    start_xfer(1'b0, 7'h50, 8'h40, 3'd0, 32'h0);
    byte_op("w0 dev", CS | CW, 8'hA0, 1'b0, 8'h00);
    byte_op("w0 reg", CP | CW, 8'h40, 1'b0, 8'h00);
    end_chk("w0", 1'b0, 1'b0);

    // read len=0 transfers one byte; upper bytes keep old values
    start_xfer(1'b1, 7'h50, 8'h05, 3'd0, 32'h0);
    byte_op("r0 dev", CS | CW, 8'hA0, 1'b0, 8'h00);
    byte_op("r0 reg", CW, 8'h05, 1'b0, 8'h00);
    byte_op("r0 devr", CS | CW, 8'hA1, 1'b0, 8'h00);
    byte_op("r0 b0", CR | CP | CA, 8'h00, 1'b0, 8'h5A);
    chk("r0 rdata", rdata, 32'h0033225A);
    end_chk("r0", 1'b0, 1'b0);

    // len=7 clamps to 4
    start_xfer(1'b0, 7'h50, 8'h06, 3'd7, 32'h44332211);
    byte_op("cl dev", CS | CW, 8'hA0, 1'b0, 8'h00);
    byte_op("cl reg", CW, 8'h06, 1'b0, 8'h00);
    byte_op("cl d0", CW, 8'h11, 1'b0, 8'h00);
    byte_op("cl d1", CW, 8'h22, 1'b0, 8'h00);
    byte_op("cl d2", CW, 8'h33, 1'b0, 8'h00);
    byte_op("cl d3", CP | CW, 8'h44, 1'b0, 8'h00);
    end_chk("cl", 1'b0, 1'b0);

    // NACK on a byte that already carried stop: no abort stop
    start_xfer(1'b0, 7'h50, 8'h09, 3'd1, 32'h66);
    byte_op("ns dev", CS | CW, 8'hA0, 1'b0, 8'h00);
    byte_op("ns reg", CW, 8'h09, 1'b0, 8'h00);
    byte_op("ns d0", CP | CW, 8'h66, 1'b1, 8'h00);
    end_chk("ns", 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("ns no abort", 32'(cmd), 32'd0);
    end

    // reset in the middle of RDATA
    start_xfer(1'b1, 7'h50, 8'h07, 3'd2, 32'h0);
    byte_op("rr dev", CS | CW, 8'hA0, 1'b0, 8'h00);
    byte_op("rr reg", CW, 8'h07, 1'b0, 8'h00);
    byte_op("rr devr", CS | CW, 8'hA1, 1'b0, 8'h00);
    wait_cmd("rr b0");
    chk("rr b0 cmd", 32'(cmd), 32'(CR));
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    chk("rr cmd", 32'(cmd), 32'd0);
    chk("rr busy", 32'(busy), 32'd0);
    chk("rr rdata", rdata, 32'd0);
    chk("rr flags", 32'({xfer_done, err_nack, err_al}), 32'd0);
    @(negedge clk);

    // normal transfer after reset
    start_xfer(1'b0, 7'h50, 8'h08, 3'd1, 32'h99);
    byte_op("pr dev", CS | CW, 8'hA0, 1'b0, 8'h00);
    byte_op("pr reg", CW, 8'h08, 1'b0, 8'h00);
    byte_op("pr d0", CP | CW, 8'h99, 1'b0, 8'h00);
    end_chk("pr", 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
